// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer that lets two requesters share one single-port data RAM.
// Each access takes 3 cycles: grant (IDLE), RAM command (ACCESS), done/response (RESP).
module ram_port_arbiter #(
  parameter int DEPTH = 32,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_done,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_b_q, last_b_d;   // 1: port B was granted last
  logic          owner_q, owner_d;     // 1: current access belongs to port B
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic in_range;
  logic sel_a;
  logic sel_b;

  // Handshake: a requester holds req (with we/addr/wdata stable) until it sees
  // gnt high in IDLE; the command is taken at that clock edge. done follows
  // gnt by exactly 2 cycles. A req still high after gnt is a fresh request.
  assign in_range = (addr_q < AW'(DEPTH));
  assign sel_a    = a_req && (!b_req || last_b_q);
  assign sel_b    = b_req && !sel_a;

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_a) begin
          a_gnt    = 1'b1;
          we_d     = a_we;
          addr_d   = a_addr;
          wdata_d  = a_wdata;
          owner_d  = 1'b0;
          last_b_d = 1'b0;
          state_d  = ACCESS;
        end else if (sel_b) begin
          b_gnt    = 1'b1;
          we_d     = b_we;
          addr_d   = b_addr;
          wdata_d  = b_wdata;
          owner_d  = 1'b1;
          last_b_d = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        err_d   = !in_range;
        rdata_d = (in_range && !we_q) ? mem_rdata : '0;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM command and response outputs are gated by state so they are zero
  // everywhere except the single cycle they belong to.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    a_done    = 1'b0;
    b_done    = 1'b0;
    err       = 1'b0;
    rdata     = '0;
    if (state_q == ACCESS) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_we    = in_range && we_q;
      mem_re    = in_range && !we_q;
    end
    if (state_q == RESP) begin
      a_done = !owner_q;
      b_done = owner_q;
      err    = err_q;
      rdata  = rdata_q;
    end
  end

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed requests, scoreboard of expected responses,
// and a monitor that checks done/err/rdata, grant-to-done latency and RAM enables.
module tb_ram_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_done, b_gnt, b_done;
  logic [DW-1:0] rdata;
  logic          err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_gnt_cyc [2];
  logic prev_gnt = 1'b0;

  // {port, err, rdata}
  logic [65:0] exp_q[$];

  logic [DW-1:0] ram [32];

  ram_port_arbiter #(.DEPTH(32), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done),
    .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Bench RAM: combinational read, write on clock edge
  initial for (int i = 0; i < 32; i++) ram[i] = '0;
  assign mem_rdata = ram[mem_addr[4:0]];
  always @(posedge clk) if (mem_we) ram[mem_addr[4:0]] <= mem_wdata;

  task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [65:0] e;
    int port;
    if (rst) begin
      check("gnt_exclusive", {a_gnt, b_gnt} == 2'b11, 1'b0);
      if (a_gnt || b_gnt) last_gnt_cyc[b_gnt ? 1 : 0] = cyc;
      if (mem_we || mem_re) begin
        check("enables_exclusive", mem_we && mem_re, 1'b0);
        check("enable_after_gnt", prev_gnt, 1'b1);
      end
      if (a_done || b_done) begin
        check("done_exclusive", a_done && b_done, 1'b0);
        port = b_done ? 1 : 0;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("resp_port_err_rdata", {b_done, err, rdata}, e);
          check("gnt_to_done_latency", cyc - last_gnt_cyc[port], 2);
        end
      end
      prev_gnt = a_gnt || b_gnt;
    end else begin
      prev_gnt = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
    #3;
    check("reset_outputs",
          {a_gnt, a_done, b_gnt, b_done, err, mem_we, mem_re, rdata, mem_addr, mem_wdata},
          '0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_req(input bit port, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input bit exp_err,
                         input logic [DW-1:0] exp_rdata);
    bit got;
    bit ok;
    exp_q.push_back({port, exp_err, exp_rdata});
    @(posedge clk); #1;
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = port ? b_gnt : a_gnt;
    end
    check("gnt_seen", got, 1'b1);
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    if (got) begin
      @(negedge clk);
      ok = (addr < 64'd32);
      check("access_cmd", {mem_we, mem_re, mem_addr}, {we && ok, !we && ok, addr});
    end
    @(posedge clk);
    @(posedge clk);
  endtask

  // Both ports read addr 2 continuously for n cycles starting from a fresh reset
  task automatic both_hold(input int n);
    for (int k = 0; k < n / 3; k++) exp_q.push_back({k[0], 1'b0, 64'h7});
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_addr = 64'd2;
    b_req = 1; b_we = 0; b_addr = 64'd2;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rr_grant_pattern", {a_gnt, b_gnt}, {i % 6 == 0, i % 6 == 3});
    end
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    @(posedge clk);
    @(posedge clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    idle_inputs();
    rst = 1'b0;
    do_reset();

    // 1: write A addr 2 = 7
    run_req(0, 1, 64'd2, 64'h7, 0, 64'h0);
    // 2: read B addr 2 -> 7
    run_req(1, 0, 64'd2, 64'h0, 0, 64'h7);

    // 3: continuous contention after reset alternates A, B, A, B
    do_reset();
    both_hold(12);

    // 4: out-of-range reads on A
    run_req(0, 0, 64'd40, 64'h0, 1, 64'h0);
    run_req(0, 0, 64'd33, 64'h0, 1, 64'h0);
    run_req(0, 0, 64'h8000_0000_0000_0000, 64'h0, 1, 64'h0);
    run_req(0, 0, 64'h1_0000_0002, 64'h0, 1, 64'h0);

    // 5: boundary addresses on B
    run_req(1, 1, 64'd31, 64'hAB, 0, 64'h0);
    run_req(1, 0, 64'd31, 64'h0, 0, 64'hAB);
    run_req(1, 1, 64'd32, 64'hCD, 1, 64'h0);
    run_req(1, 0, 64'd32, 64'h0, 1, 64'h0);
    run_req(0, 1, 64'd3, 64'hFFFF_0000_1234_5678, 0, 64'h0);
    run_req(1, 0, 64'd3, 64'h0, 0, 64'hFFFF_0000_1234_5678);

    // 6: reset during ACCESS of a write aborts it
    @(posedge clk); #1;
    a_req = 1; a_we = 1; a_addr = 64'd5; a_wdata = 64'h55;
    @(negedge clk);
    check("abort_gnt", a_gnt, 1'b1);
    @(posedge clk); #1;
    a_req = 0;
    #1;
    check("abort_we_before", mem_we, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("abort_we_dropped", {mem_we, mem_re}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_done_after_abort", {a_done, b_done}, 2'b00);
    end
    check("abort_no_write", ram[5], 64'h0);
    both_hold(6);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
